dram_readout_scheduler: RTL and testbench

- Reads a triggered capture window back out of the DRAM ring buffer that the channel write path fills.
- Issues Avalon-style read bursts starting at a word address supplied by the trigger logic, wrapping inside the ring region.
- Limits outstanding reads by free space in the downstream host FIFO, because read data cannot be back-pressured.
- Forwards returned data, registered, to that FIFO.

---
 rtl/dram_pkg.sv | 9 +
 rtl/dram_ring_addr_step.sv | 18 +
 rtl/dram_readout_scheduler.sv | 108 ++++++++++
 tb/tb_dram_readout_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: shared DRAM widths, burst geometry and readout FSM states.
package dram_pkg;
  localparam int DRAM_ADDR_W = 25;
  localparam int DRAM_DATA_W = 256;
  localparam int DRAM_BURST_W = 5;
  localparam int DRAM_BURST_LEN = 16;
  localparam int DRAM_BURST_LOG2 = $clog2(DRAM_BURST_LEN);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/dram_ring_addr_step.sv
// dram_ring_addr_step: advances a word address by one burst, wrapping inside the capture ring.
module dram_ring_addr_step #(
  parameter int ADDR_W = 25,
  parameter int BURST_LEN = 16,
  parameter int RING_BASE = 0,
  parameter int RING_WORDS = 1 << 24
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr
);
  localparam logic [ADDR_W:0] RING_END = (ADDR_W+1)'(RING_BASE + RING_WORDS);
  localparam logic [ADDR_W:0] RING_SIZE = (ADDR_W+1)'(RING_WORDS);
  logic [ADDR_W:0] sum;
  always_comb begin
    sum = {1'b0, addr} + (ADDR_W+1)'(BURST_LEN);
    next_addr = ADDR_W'(sum >= RING_END ? sum - RING_SIZE : sum);
  end
endmodule

// File: rtl/dram_readout_scheduler.sv
// dram_readout_scheduler: credit-limited burst readout of a triggered window from the DRAM capture ring.
module dram_readout_scheduler
  import dram_pkg::*;
#(
  parameter int ADDR_W = DRAM_ADDR_W,
  parameter int DATA_W = DRAM_DATA_W,
  parameter int BURST_LEN = DRAM_BURST_LEN,
  parameter int RING_BASE = 0,
  parameter int RING_WORDS = 1 << 24,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH = 512,
  parameter int USEDW_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [15:0]             num_bursts,
  output logic                    busy,
  output logic                    done,
  output logic                    err_unexpected,
  input  logic                    dram_wait_request,
  output logic                    dram_read,
  output logic [ADDR_W-1:0]       dram_read_addr,
  output logic [DRAM_BURST_W-1:0] dram_burst_count,
  input  logic [DATA_W-1:0]       dram_read_data,
  input  logic                    dram_read_data_valid,
  input  logic [USEDW_W-1:0]      fifo_usedw,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data
);
  localparam int BL_LOG2 = $clog2(BURST_LEN);
  localparam int WR_W = 16 + BL_LOG2;
  localparam int OB_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CR_W = USEDW_W + 2;
  rd_state_t state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, step_addr;
  logic [15:0] remaining, nb;
  logic [WR_W-1:0] words_received, wr_inc;
  logic [OB_W-1:0] outstanding_bursts;
  logic [CR_W-1:0] outstanding_words, credit_sum;
  logic pend, accept, ret, stray, can_issue, burst_end, last_word;
  dram_ring_addr_step #(
    .ADDR_W(ADDR_W),
    .BURST_LEN(BURST_LEN),
    .RING_BASE(RING_BASE),
    .RING_WORDS(RING_WORDS)
  ) u_step (
    .addr(cur_addr),
    .next_addr(step_addr)
  );
  assign busy = state == ISSUE || state == DRAIN;
  assign done = state == DONE;
  assign dram_read_addr = cur_addr;
  assign dram_burst_count = DRAM_BURST_W'(BURST_LEN);
  // A stalled request (pend) is held regardless of credit so the Avalon request never retracts.
  always_comb begin
    credit_sum = CR_W'(fifo_usedw) + outstanding_words + CR_W'(BURST_LEN);
    can_issue = remaining != '0 && outstanding_bursts < OB_W'(MAX_OUTSTANDING) && credit_sum <= CR_W'(FIFO_DEPTH);
    dram_read = state == ISSUE && (pend || can_issue);
    accept = dram_read && !dram_wait_request;
    ret = busy && dram_read_data_valid && outstanding_words != '0;
    stray = busy && dram_read_data_valid && outstanding_words == '0;
    wr_inc = words_received + 1'b1;
    burst_end = (wr_inc & WR_W'(BURST_LEN - 1)) == '0;
    last_word = ret && wr_inc == (WR_W'(nb) << BL_LOG2);
    state_nxt = state == IDLE  ? (start ? (num_bursts == '0 ? DONE : ISSUE) : IDLE)
              : state == ISSUE ? (accept && remaining == 16'd1 ? DRAIN : ISSUE)
              : state == DRAIN ? (last_word ? DONE : DRAIN)
              : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      nb <= '0;
      words_received <= '0;
      outstanding_bursts <= '0;
      outstanding_words <= '0;
      pend <= 1'b0;
      err_unexpected <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      pend <= dram_read && dram_wait_request;
      out_valid <= ret;
      if (ret) out_data <= dram_read_data;
      if (state == IDLE && start) begin
        cur_addr <= start_addr & ~ADDR_W'(BURST_LEN - 1);
        remaining <= num_bursts;
        nb <= num_bursts;
        words_received <= '0;
        outstanding_bursts <= '0;
        outstanding_words <= '0;
        err_unexpected <= 1'b0;
      end else begin
        if (accept) cur_addr <= step_addr;
        if (accept) remaining <= remaining - 1'b1;
        if (ret) words_received <= wr_inc;
        outstanding_bursts <= outstanding_bursts + OB_W'(accept) - OB_W'(ret && burst_end);
        outstanding_words <= outstanding_words + (accept ? CR_W'(BURST_LEN) : '0) - CR_W'(ret);
        if (stray) err_unexpected <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dram_readout_scheduler.sv
// tb_dram_readout_scheduler: randomized readout runs checked against an address/data reference model.
module tb_dram_readout_scheduler;
  localparam int AW = 25, DW = 64, BL = 16, RB = 256, RW = 1024, MO = 2, FD = 512, UW = 10;
  logic clk = 0, rst_n = 0, start = 0;
  logic [AW-1:0] start_addr = '0;
  logic [15:0] num_bursts = '0;
  logic busy, done, err_unexpected, dram_read, out_valid;
  logic dram_wait_request = 0, dram_read_data_valid = 0;
  logic [AW-1:0] dram_read_addr;
  logic [4:0] dram_burst_count;
  logic [DW-1:0] dram_read_data = '0, out_data;
  logic [UW-1:0] fifo_usedw = '0;
  int n_chk = 0, n_pass = 0;
  int s_addr = 0, nb = 0, n_acc = 0, n_ret = 0, n_out = 0, n_done = 0, n_ov_any = 0, n_rd_any = 0;
  int cyc = 0, lat = 3, gap = 0, sj = 0, prev_addr = 0;
  bit mon_en = 0, pend_prev = 0, rand_wait = 0, withhold = 0, force_wait = 0, inject = 0, junk_now = 0;
  int sq_a[$], sq_r[$];
  always #5 clk = ~clk;
  dram_readout_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .RING_BASE(RB), .RING_WORDS(RW),
    .MAX_OUTSTANDING(MO), .FIFO_DEPTH(FD), .USEDW_W(UW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .num_bursts(num_bursts),
    .busy(busy), .done(done), .err_unexpected(err_unexpected),
    .dram_wait_request(dram_wait_request), .dram_read(dram_read), .dram_read_addr(dram_read_addr),
    .dram_burst_count(dram_burst_count), .dram_read_data(dram_read_data),
    .dram_read_data_valid(dram_read_data_valid), .fifo_usedw(fifo_usedw),
    .out_valid(out_valid), .out_data(out_data)
  );
  function automatic int burst_addr(int s, int i);
    return RB + ((s - RB + i * BL) % RW);
  endfunction
  function automatic logic [DW-1:0] word_of(int a);
    logic [31:0] u;
    u = a;
    return {u ^ 32'hA5C3_0000, u * 32'h9E37_79B1};
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic arm(int a, int n);
    s_addr = a & ~(BL - 1);
    nb = n;
    n_acc = 0; n_ret = 0; n_out = 0; n_done = 0;
    pend_prev = 0;
    mon_en = 1;
  endtask
  task automatic kick(int a, int n);
    sync();
    start_addr = AW'(a);
    num_bursts = 16'(n);
    start = 1;
    sync();
    start = 0;
  endtask
  task automatic wait_done(int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) step(1);
    chk("done_seen", n_done > d0, 1);
  endtask
  task automatic post(int n, bit e);
    chk("accepts", n_acc, n);
    chk("words", n_out, n * BL);
    chk("done_once", n_done, 1);
    step(3);
    chk("idle_busy", busy, 0);
    chk("single_done", n_done, 1);
    chk("err_state", err_unexpected, e);
  endtask
  task automatic chk_reset(string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_err"}, err_unexpected, 0);
    chk({p, "_read"}, dram_read, 0);
    chk({p, "_addr"}, dram_read_addr, 0);
    chk({p, "_bcount"}, dram_burst_count, BL);
    chk({p, "_ovalid"}, out_valid, 0);
    chk({p, "_odata"}, out_data, 0);
  endtask
  // Slave: accepted bursts return BL words after lat cycles, optionally gapped or withheld.
  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    dram_wait_request = force_wait || (rand_wait && $urandom_range(3) == 0);
    junk_now = 0;
    if (inject) begin
      inject = 0;
      junk_now = 1;
      dram_read_data_valid = 1;
      dram_read_data = 64'hDEAD_BEEF_0BAD_F00D;
    end else if (!withhold && sq_a.size() > 0 && cyc >= sq_r[0] && $urandom_range(99) >= gap) begin
      dram_read_data_valid = 1;
      dram_read_data = word_of(sq_a[0] + sj);
      sj++;
      if (sj == BL) begin
        sj = 0;
        void'(sq_a.pop_front());
        void'(sq_r.pop_front());
      end
    end else dram_read_data_valid = 0;
  end
  // Monitor: outputs are sampled mid-cycle; events seen here take effect at the next rising edge.
  initial forever begin
    @(negedge clk);
    if (out_valid) n_ov_any++;
    if (dram_read) n_rd_any++;
    if (mon_en) begin
      if (pend_prev) begin
        chk("hold_read", dram_read, 1);
        chk("hold_addr", dram_read_addr, prev_addr);
      end else if (dram_read) begin
        chk("credit", fifo_usedw + (n_acc * BL - n_ret) + BL <= FD, 1);
        chk("max_outstanding", n_acc - n_ret / BL < MO, 1);
      end
      if (dram_read && !dram_wait_request) begin
        chk("read_addr", dram_read_addr, n_acc < nb ? burst_addr(s_addr, n_acc) : -1);
        sq_a.push_back(int'(dram_read_addr));
        sq_r.push_back(cyc + lat);
        n_acc++;
      end
      if (dram_read_data_valid && !junk_now) n_ret++;
      if (out_valid) begin
        chk("out_data", out_data, n_out < nb * BL ? word_of(burst_addr(s_addr, n_out / BL) + n_out % BL) : '1);
        n_out++;
      end
      if (done) begin
        n_done++;
        chk("done_words", n_out, nb * BL);
        chk("done_busy", busy, 0);
        chk("done_last_word", out_valid, nb != 0);
      end
      pend_prev = dram_read && dram_wait_request;
      prev_addr = int'(dram_read_addr);
    end
  end
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int a, n, ov0, rd0;
    sync();
    sync();
    step(1);
    chk_reset("rst");
    sync();
    rst_n = 1;
    arm(32'h100, 4);
    kick(32'h100, 4);
    step(4);
    kick(32'h300, 9);
    wait_done(1000);
    post(4, 0);
    arm(32'h4F7, 3);
    kick(32'h4F7, 3);
    wait_done(1000);
    post(3, 0);
    arm(32'h100, 0);
    rd0 = n_rd_any;
    sync();
    start_addr = AW'(32'h100);
    num_bursts = 0;
    start = 1;
    step(1);
    chk("zero_done_early", done, 0);
    sync();
    start = 0;
    step(1);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    step(1);
    chk("zero_done_pulse", done, 0);
    chk("zero_no_read", n_rd_any, rd0);
    withhold = 1;
    sync();
    fifo_usedw = 500;
    arm(32'h200, 3);
    kick(32'h200, 3);
    step(10);
    chk("stall_none", n_acc, 0);
    chk("stall_read", dram_read, 0);
    sync();
    fifo_usedw = 496;
    step(10);
    chk("stall_one", n_acc, 1);
    sync();
    fifo_usedw = 0;
    step(10);
    chk("stall_max", n_acc, 2);
    sync();
    withhold = 0;
    wait_done(1000);
    post(3, 0);
    force_wait = 1;
    arm(32'h220, 1);
    kick(32'h220, 1);
    for (int i = 0; i < 10 && !dram_read; i++) step(1);
    chk("wr_req_seen", dram_read, 1);
    step(4);
    chk("wr_no_accept", n_acc, 0);
    chk("wr_still_req", dram_read, 1);
    sync();
    force_wait = 0;
    wait_done(500);
    post(1, 0);
    sync();
    fifo_usedw = 512;
    arm(32'h120, 1);
    kick(32'h120, 1);
    step(3);
    chk("spur_busy", busy, 1);
    chk("spur_idle_read", dram_read, 0);
    sync();
    inject = 1;
    step(2);
    chk("spur_err", err_unexpected, 1);
    chk("spur_ovalid", out_valid, 0);
    step(1);
    chk("spur_no_word", n_out, 0);
    sync();
    fifo_usedw = 0;
    wait_done(500);
    post(1, 1);
    withhold = 1;
    arm(32'h180, 4);
    kick(32'h180, 4);
    step(1);
    chk("err_cleared", err_unexpected, 0);
    for (int i = 0; i < 20 && n_acc < 2; i++) step(1);
    chk("mid_accepts", n_acc, 2);
    sync();
    rst_n = 0;
    mon_en = 0;
    @(posedge clk);
    step(1);
    chk_reset("mid");
    sync();
    rst_n = 1;
    withhold = 0;
    ov0 = n_ov_any;
    rd0 = n_rd_any;
    step(60);
    chk("stray_no_out", n_ov_any, ov0);
    chk("stray_no_read", n_rd_any, rd0);
    chk("stray_err", err_unexpected, 0);
    chk("stray_busy", busy, 0);
    rand_wait = 1;
    for (int k = 0; k < 8; k++) begin
      a = RB + int'($urandom_range(RW - 1));
      n = int'($urandom_range(1, 5));
      lat = int'($urandom_range(1, 6));
      gap = int'($urandom_range(0, 40));
      sync();
      fifo_usedw = UW'($urandom_range(0, 400));
      arm(a, n);
      kick(a, n);
      wait_done(3000);
      post(n, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
